// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Default queue entry for a 32-bit core; fetch_queue builds an XLEN-sized twin.
    typedef struct packed {
        logic [31:0]         pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush, used as the decoded-side fetch buffer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array is deliberately not reset; count gates every read,
    // so stale contents are never observed and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Credit-limited prefetching fetch unit: sequential requests, in-order responses,
// redirect flush. Optional FETCH_MISALIGN_CHECK_EN adds the HALT state and misalign flag.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [XLEN-1:0]     out_pc,
    output logic                misalign
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W:0]   inflight;
    logic [XLEN-1:0]  redirect_tgt;
    logic             running;
    logic             req_fire;
    logic             rsp_keep;
    logic             rsp_drop;
    logic             pop;
    entry_t           push_data;
    entry_t           head;

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_state_t state;
    logic         misalign_q;
    logic         redirect_bad;

    assign redirect_tgt = redirect_pc;
    assign redirect_bad = |redirect_pc[1:0];
    assign running      = (state == RUN);
    assign misalign     = misalign_q;
`else
    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign running      = 1'b1;
    assign misalign     = 1'b0;
`endif

    // Slots already owed to in-flight requests count against the queue capacity,
    // which is what guarantees a response never meets a full queue.
    assign inflight       = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = reset && running && !redirect_valid
                            && (inflight < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = req_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign pop      = out_valid && out_ready;

    assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples this cycle's values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            state       <= RUN;
            misalign_q  <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still owed by memory belongs to the old path.
                req_pc   <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                drop_cnt <= outstanding_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
                state      <= redirect_bad ? HALT : RUN;
                misalign_q <= redirect_bad;
`endif
            end else begin
                if (req_fire) req_pc   <= req_pc + XLEN'(PC_STEP);
                if (rsp_keep) rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
                if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    assign push_data = '{pc: rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against an epoch-based stream model of fetch.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign       (misalign)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    // Model: memory pipe tagged with the fetch path (epoch) and the decode-side
    // stream of instructions expected from the current path.
    ent_t        mq[$];
    mreq_t       mem[$];
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_req = RESET_PC;
    bit          halted = 1'b0;
    bit          exp_mis = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic cycle(input bit rd, input logic [31:0] tgt, input bit ordy, input bit mrdy);
        mreq_t       r;
        mreq_t       n;
        bit          rv;
        bit          exp_rv;
        int          due;
        logic [31:0] t;

        @(negedge clk);
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
        end
        check("misalign", misalign, exp_mis);

        out_ready      = ordy;
        imem_req_ready = mrdy;
        redirect_valid = rd;
        redirect_pc    = tgt;
        rv = 1'b0;
        if (mem.size() != 0 && mem[0].due <= cyc) begin
            r  = mem.pop_front();
            rv = 1'b1;
        end
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mem_word(r.addr) : $urandom;
        #1;

        // Every fetch owed by memory or sitting in the buffer uses one of DEPTH slots.
        exp_rv = !halted && !rd && ((mem.size() + int'(rv) + mq.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (imem_req_valid && mrdy) begin
            check("req_addr", imem_req_addr, exp_req);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            n = '{addr: imem_req_addr, epoch: epoch, due: due};
            mem.push_back(n);
            exp_req = exp_req + 32'd4;
        end

        if (ordy && mq.size() != 0) void'(mq.pop_front());
        if (rv && r.epoch == epoch && !rd) mq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
        if (rd) begin
            epoch++;
            mq.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            t       = tgt;
            halted  = (tgt[1:0] != 2'b00);
            exp_mis = halted;
`else
            t = {tgt[31:2], 2'b00};
`endif
            exp_req = t;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        check("rst_misalign", misalign, 0);
        mem.delete();
        mq.delete();
        epoch++;
        exp_req  = RESET_PC;
        halted   = 1'b0;
        exp_mis  = 1'b0;
        last_due = cyc;
        rst_n    = 1'b1;
        #1;
        check("rst_release_req_valid", imem_req_valid, 1);
        check("rst_release_req_addr", imem_req_addr, RESET_PC);
    endtask

    initial begin
        do_reset();

        // Streaming with a single-cycle memory and an always-ready decoder.
        repeat (30) cycle(0, '0, 1, 1);

        // Decoder stalls: credit must cap outstanding-plus-buffered at DEPTH.
        repeat (12) cycle(0, '0, 0, 1);
        repeat (12) cycle(0, '0, 1, 1);

        // Slow memory, redirect with stale responses still in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (5) cycle(0, '0, 1, 1);
        cycle(1, 32'h0000_0200, 1, 1);
        repeat (12) cycle(0, '0, 1, 1);

        // Address wrap at the top of the address space.
        lat_min = 1;
        lat_max = 1;
        cycle(1, 32'hFFFF_FFF8, 1, 1);
        repeat (10) cycle(0, '0, 1, 1);

        // Misaligned redirect, then an aligned one.
        cycle(1, 32'h0000_0202, 1, 1);
        repeat (8) cycle(0, '0, 1, 1);
        cycle(1, 32'h0000_0300, 1, 1);
        repeat (8) cycle(0, '0, 1, 1);

        // Randomized traffic: latency, back-pressure, redirects (incl. back-to-back).
        for (int i = 0; i < 3000; i++) begin
            bit          rd;
            logic [31:0] tgt;
            if (i % 200 == 0) lat_max = int'($urandom_range(4, 1));
            rd = ($urandom_range(99, 0) < 5);
            case ($urandom_range(3, 0))
                0:       tgt = {$urandom, 2'b00} >> 2 << 2;
                1:       tgt = 32'hFFFF_FFF0 | {28'd0, $urandom_range(3, 0) == 0 ? 4'h0 : 4'hC};
                2:       tgt = $urandom;
                default: tgt = 32'h0000_0200;
            endcase
            cycle(rd, tgt, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 80);
        end

        // Reset in the middle of a burst, then restart from RESET_PC.
        lat_min = 2;
        lat_max = 2;
        cycle(1, 32'h0000_0400, 1, 1);
        repeat (6) cycle(0, '0, 1, 1);
        do_reset();
        repeat (20) cycle(0, '0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
